// File: rtl/seq_mult_stream.sv
// Digit-serial P-bit multiplier: one partial product per cycle, product streamed
// LSB-first as 2N/P digits over a valid/ready handshake.
module seq_mult_stream #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MAX_WIDTH-1:0]       a,
  input  logic [MAX_WIDTH-1:0]       b,
  input  logic [$clog2(MAX_WIDTH):0] bitsize,
  input  logic                       signed_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [P-1:0]               p,
  output logic                       out_last,
  output logic                       done,
  output logic                       err
);

  localparam int DM    = MAX_WIDTH / P;
  localparam int DW    = $clog2(DM);
  localparam int KW    = DW + 1;
  localparam int BSW   = $clog2(MAX_WIDTH) + 1;
  localparam int LP    = $clog2(P);
  localparam int PPW   = 2 * P + 2;
  localparam int ACC_W = 2 * P + $clog2(DM) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT} state_t;

  state_t                    r_state, w_state_next;
  logic [MAX_WIDTH-1:0]      r_a, r_b;
  logic                      r_signed;
  logic [DW-1:0]             r_dm1, r_i, r_j;
  logic [KW-1:0]             r_k;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_done, r_err;

  logic [P-1:0]              w_a_digs [DM];
  logic [P-1:0]              w_b_digs [DM];
  logic [P-1:0]              w_a_dig, w_b_dig;
  logic signed [P:0]         w_a_ext, w_b_ext;
  logic signed [PPW-1:0]     w_pp;
  logic signed [ACC_W-1:0]   w_pp_ext;
  logic                      w_illegal, w_col_last;
  logic [DW-1:0]             w_dm1_in, w_ilo_next, w_j_next;
  logic [KW-1:0]             w_k_next, w_kmax;

  generate
    for (genvar gi = 0; gi < DM; gi++) begin : g_digits
      assign w_a_digs[gi] = r_a[gi*P +: P];
      assign w_b_digs[gi] = r_b[gi*P +: P];
    end
  endgenerate

  // Only the top digit of a signed operand carries negative weight.
  assign w_a_dig  = w_a_digs[r_i];
  assign w_b_dig  = w_b_digs[r_j];
  assign w_a_ext  = {r_signed & (r_i == r_dm1) & w_a_dig[P-1], w_a_dig};
  assign w_b_ext  = {r_signed & (r_j == r_dm1) & w_b_dig[P-1], w_b_dig};
  assign w_pp     = PPW'(w_a_ext) * PPW'(w_b_ext);
  assign w_pp_ext = ACC_W'(w_pp);

  assign w_illegal = (bitsize == '0) || (bitsize > BSW'(MAX_WIDTH)) ||
                     ((bitsize & BSW'(P - 1)) != '0);
  assign w_dm1_in  = DW'((bitsize >> LP) - BSW'(1));

  // Column k walks i upward / j downward until either hits its bound.
  assign w_col_last = (r_i == r_dm1) || (r_j == '0);
  assign w_kmax     = {r_dm1, 1'b1};
  assign w_k_next   = r_k + KW'(1);
  assign w_ilo_next = (w_k_next > {1'b0, r_dm1}) ? DW'(w_k_next - {1'b0, r_dm1}) : '0;
  assign w_j_next   = DW'(w_k_next - {1'b0, w_ilo_next});

  assign done = r_done;
  assign err  = r_err;

  always_ff @(posedge clk) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    p            = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !w_illegal) w_state_next = S_MAC;
      end
      S_MAC: begin
        if (w_col_last) w_state_next = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        p         = r_acc[P-1:0];
        out_last  = (r_k == w_kmax);
        if (out_ready) begin
          if (r_k == w_kmax)          w_state_next = S_IDLE;
          else if (w_k_next != w_kmax) w_state_next = S_MAC;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_dm1    <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_illegal) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_a      <= a;
              r_b      <= b;
              r_signed <= signed_mode;
              r_dm1    <= w_dm1_in;
              r_i      <= '0;
              r_j      <= '0;
              r_k      <= '0;
              r_acc    <= '0;
            end
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_pp_ext;
          if (!w_col_last) begin
            r_i <= r_i + DW'(1);
            r_j <= r_j - DW'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_acc <= r_acc >>> P;
            if (r_k == w_kmax) begin
              r_done <= 1'b1;
            end else begin
              r_k <= w_k_next;
              r_i <= w_ilo_next;
              r_j <= w_j_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_stream.sv
// Randomized bench for seq_mult_stream: digits, timing and handshakes compared
// against an arithmetic product model.
module tb_seq_mult_stream;
  localparam int P   = 2;
  localparam int MW  = 16;
  localparam int BSW = $clog2(MW) + 1;

  logic           clk = 1'b0;
  logic           rst_n, in_valid, in_ready, signed_mode;
  logic           out_valid, out_ready, out_last, done, err;
  logic [MW-1:0]  a, b;
  logic [BSW-1:0] bitsize;
  logic [P-1:0]   p;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_mult_stream #(.P(P), .MAX_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bitsize(bitsize), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .out_last(out_last),
    .done(done), .err(err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input logic [MW-1:0] av, input logic [MW-1:0] bv,
                                           input int n, input logic sgn);
    logic [63:0] m, x, y;
    m = (64'd1 << n) - 64'd1;
    x = {48'd0, av} & m;
    y = {48'd0, bv} & m;
    if (sgn && x[n-1]) x = x | ~m;
    if (sgn && y[n-1]) y = y | ~m;
    return (x * y) & ((64'd1 << (2 * n)) - 64'd1);
  endfunction

  // Called at a sample point (#1 after a rising edge); returns at one too.
  task automatic run_op(input logic [MW-1:0] av, input logic [MW-1:0] bv, input int n,
                        input logic sgn, input int stall_d0, input int stall_d1,
                        input bit rand_bp, input bit keep_valid, input int abort_after);
    logic [63:0] prod, dig;
    logic [P-1:0] prev_p;
    logic prev_last;
    int nd, d, idx, stalls, st_cnt, t, fails0;
    bit legal, prev_stall, finished, rdy;
    legal  = (n > 0) && (n <= MW) && (n % P == 0);
    d      = n / P;
    nd     = 2 * d;
    prod   = ref_prod(av, bv, n, sgn);
    fails0 = n_checks - n_pass;
    check_val("in_ready_idle", in_ready, 1);
    a = av; b = bv; bitsize = n[BSW-1:0]; signed_mode = sgn;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    if (!keep_valid) in_valid = 1'b0;
    if (!legal) begin
      check_val("ill_done", done, 1);
      check_val("ill_err", err, 1);
      check_val("ill_valid", out_valid, 0);
      check_val("ill_ready", in_ready, 1);
      $display("txn illegal n=%0d errors=%0d", n, (n_checks - n_pass) - fails0);
      return;
    end
    idx = 0; stalls = 0; st_cnt = 0; prev_stall = 0; finished = 0;
    prev_p = '0; prev_last = 0;
    for (t = 0; t < 3000 && !finished; t++) begin
      if (abort_after >= 0 && idx == abort_after) begin
        rst_n = 1'b1;
        tick();
        check_val("rst_valid", out_valid, 0);
        check_val("rst_p", p, 0);
        check_val("rst_last", out_last, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_ready", in_ready, 1);
        rst_n = 1'b0;
        tick();
        check_val("rst_no_valid", out_valid, 0);
        $display("txn aborted n=%0d after %0d digits errors=%0d", n, idx,
                 (n_checks - n_pass) - fails0);
        return;
      end
      if (done) check_val("early_done", done, 0);
      if (prev_stall) begin
        check_val("stall_valid", out_valid, 1);
        check_val("stall_p", p, prev_p);
        check_val("stall_last", out_last, prev_last);
      end
      if (out_valid) begin
        if (idx == 0 && !prev_stall) check_val("first_valid_cycle", t + 1, 2);
        dig = (prod >> (P * idx)) & ((64'd1 << P) - 64'd1);
        check_val("digit", p, dig);
        check_val("out_last", out_last, (idx == nd - 1) ? 1 : 0);
        if ((idx == stall_d0 || idx == stall_d1) && st_cnt < 5) begin
          rdy = 0; st_cnt++;
        end else if (rand_bp && $urandom_range(0, 3) == 0) rdy = 0;
        else rdy = 1;
        out_ready  = rdy;
        prev_stall = !rdy;
        prev_p     = p;
        prev_last  = out_last;
        if (rdy) begin
          if (idx == nd - 1) begin
            finished = 1;
            check_val("latency", t + 1, d * d + 2 * d + stalls);
          end
          idx++;
          st_cnt = 0;
        end else stalls++;
      end else begin
        prev_stall = 0;
        out_ready  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick();
    end
    if (!finished) begin
      check_val("timeout", 0, 1);
    end else begin
      check_val("done", done, 1);
      check_val("done_err", err, 0);
      check_val("done_ready", in_ready, 1);
      check_val("no_extra_digit", out_valid, 0);
    end
    out_ready = 1'b1;
    $display("txn n=%0d s=%0d a=%h b=%h prod=%h digits=%0d stalls=%0d errors=%0d",
             n, sgn, av, bv, prod, idx, stalls, (n_checks - n_pass) - fails0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bitsize = '0; signed_mode = 1'b0;
    tick(); tick();
    check_val("reset_valid", out_valid, 0);
    check_val("reset_p", p, 0);
    check_val("reset_last", out_last, 0);
    check_val("reset_done", done, 0);
    check_val("reset_err", err, 0);
    check_val("reset_ready", in_ready, 1);
    rst_n = 1'b0;
    tick();

    run_op(16'h000B, 16'h000D, 4, 1'b0, -1, -1, 0, 0, -1);
    run_op(16'h000D, 16'h0005, 4, 1'b1, -1, -1, 0, 0, -1);
    run_op(16'h8000, 16'h8000, 16, 1'b1, -1, -1, 0, 0, -1);
    run_op(16'hFFFF, 16'hFFFF, 16, 1'b0, -1, -1, 0, 0, -1);
    run_op(16'hFFFF, 16'hFFFF, 16, 1'b0, 2, 15, 0, 0, -1);
    run_op(16'(($urandom)), 16'(($urandom)), 16, 1'b1, 2, 15, 0, 0, -1);

    run_op(16'h0005, 16'h0006, 3, 1'b0, -1, -1, 0, 0, -1);
    run_op(16'h0005, 16'h0006, 6, 1'b0, -1, -1, 0, 0, -1);
    run_op(16'h0005, 16'h0006, 0, 1'b0, -1, -1, 0, 0, -1);
    run_op(16'hF0F3, 16'h1234, 8, 1'b1, -1, -1, 0, 0, -1);
    run_op(16'h0005, 16'h0006, 18, 1'b0, -1, -1, 0, 0, -1);

    run_op(16'hA5C3, 16'h3C5A, 16, 1'b0, -1, -1, 0, 0, 3);
    run_op(16'h0003, 16'h0003, 2, 1'b0, -1, -1, 0, 0, -1);

    for (int i = 0; i < 6; i++) begin
      n = 2 * $urandom_range(1, 8);
      run_op(16'($urandom), 16'($urandom), n, 1'($urandom_range(0, 1)),
             -1, -1, i[0], (i != 5), -1);
    end

    for (int i = 0; i < 40; i++) begin
      n = 2 * $urandom_range(1, 8);
      run_op(16'($urandom), 16'($urandom), n, 1'($urandom_range(0, 1)),
             -1, -1, 1, 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
